// File: rtl/axi_llc_arcane_xfer_seq_if.sv
// Command, AR/AW request and completion signals of the ARCANE line-copy sequencer.
// The master modport is the sequencer's view; slave is the LLC/software side.
interface axi_llc_arcane_xfer_seq_if #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned IdWidth       = 4,
  parameter int unsigned NumLinesWidth = 8
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [AddrWidth-1:0]     cmd_src_addr;
  logic [AddrWidth-1:0]     cmd_dst_addr;
  logic [NumLinesWidth-1:0] cmd_num_lines;
  logic                     cmd_alloc;

  logic                     ar_valid;
  logic                     ar_ready;
  logic [AddrWidth-1:0]     ar_addr;
  logic [IdWidth-1:0]       ar_id;
  logic                     ar_src_dst;

  logic                     aw_valid;
  logic                     aw_ready;
  logic [AddrWidth-1:0]     aw_addr;
  logic [IdWidth-1:0]       aw_id;
  logic                     aw_src_dst;

  logic                     line_done;
  logic                     busy;
  logic                     done;
  logic [NumLinesWidth-1:0] lines_done;

  modport master (
    input  cmd_valid, cmd_src_addr, cmd_dst_addr, cmd_num_lines, cmd_alloc,
    output cmd_ready,
    output ar_valid, ar_addr, ar_id, ar_src_dst,
    input  ar_ready,
    output aw_valid, aw_addr, aw_id, aw_src_dst,
    input  aw_ready,
    input  line_done,
    output busy, done, lines_done
  );

  modport slave (
    output cmd_valid, cmd_src_addr, cmd_dst_addr, cmd_num_lines, cmd_alloc,
    input  cmd_ready,
    input  ar_valid, ar_addr, ar_id, ar_src_dst,
    output ar_ready,
    input  aw_valid, aw_addr, aw_id, aw_src_dst,
    output aw_ready,
    output line_done,
    input  busy, done, lines_done
  );
endinterface

// File: rtl/axi_llc_arcane_xfer_seq.sv
// ARCANE line-copy sequencer: turns one copy command into per-line AR/AW requests,
// throttled by an outstanding-write limit, and reports completion.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for a command, cmd_ready high
// ST_ISSUE | emitting AR/AW line requests
// ST_DRAIN | all AWs issued, waiting for the remaining line completions
module axi_llc_arcane_xfer_seq #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned IdWidth        = 4,
  parameter int unsigned TxnId          = 0,
  parameter int unsigned LineBytes      = 64,
  parameter int unsigned NumLinesWidth  = 8,
  parameter int unsigned MaxOutstanding = 4
) (
  input logic clk_i,
  input logic rst_ni,
  axi_llc_arcane_xfer_seq_if.master bus
);

  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]               state_q;
  logic [NumLinesWidth-1:0] num_lines_q;
  logic [NumLinesWidth-1:0] ar_cnt_q;
  logic [NumLinesWidth-1:0] aw_cnt_q;
  logic [NumLinesWidth-1:0] lines_done_q;
  logic [OutW-1:0]          out_cnt_q;
  logic [AddrWidth-1:0]     ar_addr_q;
  logic [AddrWidth-1:0]     aw_addr_q;
  logic                     ar_valid_q;
  logic                     aw_valid_q;
  logic                     alloc_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     cmd_ready_q;

  logic                     cmd_hs;
  logic                     ar_hs;
  logic                     aw_hs;
  logic                     ld_ok;
  logic [NumLinesWidth-1:0] ar_cnt_d;
  logic [NumLinesWidth-1:0] aw_cnt_d;
  logic [NumLinesWidth-1:0] lines_done_d;
  logic [OutW-1:0]          out_cnt_d;

  assign cmd_hs = bus.cmd_valid & cmd_ready_q;
  assign ar_hs  = ar_valid_q & bus.ar_ready;
  assign aw_hs  = aw_valid_q & bus.aw_ready;
  // Completions are only honoured while an operation has writes in flight.
  assign ld_ok  = bus.line_done & (state_q != ST_IDLE) & (out_cnt_q != '0);

  always_comb begin
    ar_cnt_d     = ar_cnt_q + NumLinesWidth'(ar_hs);
    aw_cnt_d     = aw_cnt_q + NumLinesWidth'(aw_hs);
    out_cnt_d    = out_cnt_q;
    lines_done_d = lines_done_q;
    if (aw_hs && !ld_ok) begin
      out_cnt_d = out_cnt_q + OutW'(1);
    end else if (!aw_hs && ld_ok) begin
      out_cnt_d = out_cnt_q - OutW'(1);
    end
    if (ld_ok && (lines_done_q < num_lines_q)) begin
      lines_done_d = lines_done_q + NumLinesWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      num_lines_q  <= '0;
      ar_cnt_q     <= '0;
      aw_cnt_q     <= '0;
      lines_done_q <= '0;
      out_cnt_q    <= '0;
      ar_addr_q    <= '0;
      aw_addr_q    <= '0;
      ar_valid_q   <= 1'b0;
      aw_valid_q   <= 1'b0;
      alloc_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cmd_ready_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_hs) begin
            num_lines_q  <= bus.cmd_num_lines;
            alloc_q      <= bus.cmd_alloc;
            ar_addr_q    <= bus.cmd_src_addr;
            aw_addr_q    <= bus.cmd_dst_addr;
            ar_cnt_q     <= '0;
            aw_cnt_q     <= '0;
            out_cnt_q    <= '0;
            lines_done_q <= '0;
            cmd_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            if (bus.cmd_num_lines != '0) begin
              state_q    <= ST_ISSUE;
              ar_valid_q <= 1'b1;
            end else begin
              state_q    <= ST_DRAIN;
            end
          end
        end
        ST_ISSUE: begin
          ar_cnt_q     <= ar_cnt_d;
          aw_cnt_q     <= aw_cnt_d;
          out_cnt_q    <= out_cnt_d;
          lines_done_q <= lines_done_d;
          if (ar_hs) ar_addr_q <= ar_addr_q + AddrWidth'(LineBytes);
          if (aw_hs) aw_addr_q <= aw_addr_q + AddrWidth'(LineBytes);
          ar_valid_q <= (ar_cnt_d < num_lines_q);
          // Registered valids are monotonic in their enables, so a raised
          // valid can only fall after its own handshake.
          aw_valid_q <= (aw_cnt_d < ar_cnt_d) && (out_cnt_d < OutW'(MaxOutstanding));
          if (aw_cnt_d == num_lines_q) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          out_cnt_q    <= out_cnt_d;
          lines_done_q <= lines_done_d;
          ar_valid_q   <= 1'b0;
          aw_valid_q   <= 1'b0;
          if (lines_done_d == num_lines_q) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            cmd_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          ar_valid_q  <= 1'b0;
          aw_valid_q  <= 1'b0;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.ar_valid   = ar_valid_q;
  assign bus.ar_addr    = ar_addr_q;
  assign bus.ar_id      = IdWidth'(TxnId);
  assign bus.ar_src_dst = alloc_q;
  assign bus.aw_valid   = aw_valid_q;
  assign bus.aw_addr    = aw_addr_q;
  assign bus.aw_id      = IdWidth'(TxnId);
  assign bus.aw_src_dst = alloc_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.lines_done = lines_done_q;

endmodule

// File: tb/tb_axi_llc_arcane_xfer_seq.sv
// Directed bench for the ARCANE line-copy sequencer (MaxOutstanding = 2).
module tb_axi_llc_arcane_xfer_seq;
  localparam int unsigned AW = 32;
  localparam int unsigned IW = 4;
  localparam int unsigned NW = 8;
  localparam int unsigned MO = 2;

  localparam logic [31:0] T1_AR [4] = '{32'h8000_0000, 32'h8000_0040, 32'h8000_0080, 32'h8000_00C0};
  localparam logic [31:0] T1_AW [4] = '{32'hF000_0000, 32'hF000_0040, 32'hF000_0080, 32'hF000_00C0};
  localparam logic [31:0] T3_AR [3] = '{32'h4000_0100, 32'h4000_0140, 32'h4000_0180};
  localparam logic [31:0] T3_AW [3] = '{32'h5000_0000, 32'h5000_0040, 32'h5000_0080};

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  axi_llc_arcane_xfer_seq_if #(.AddrWidth(AW), .IdWidth(IW), .NumLinesWidth(NW)) bus ();

  axi_llc_arcane_xfer_seq #(
    .AddrWidth(AW), .IdWidth(IW), .TxnId(0), .LineBytes(64),
    .NumLinesWidth(NW), .MaxOutstanding(MO)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  logic        man_ld = 1'b0;
  logic        auto_en = 1'b0;
  logic [2:0]  pipe = '0;
  logic [31:0] ar_q[$];
  logic [31:0] aw_q[$];
  int          done_n = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  // Responder: completes each AW line two cycles after its handshake.
  assign bus.line_done = man_ld | (auto_en & pipe[2]);

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      pipe = '0;
    end else begin
      if (bus.ar_valid && bus.ar_ready) ar_q.push_back(bus.ar_addr);
      if (bus.aw_valid && bus.aw_ready) aw_q.push_back(bus.aw_addr);
      if (bus.done) done_n++;
      pipe = {pipe[1:0], bus.aw_valid & bus.aw_ready};
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send_cmd(input logic [31:0] src, input logic [31:0] dst,
                          input logic [7:0] n, input logic alloc);
    bus.cmd_src_addr  = src;
    bus.cmd_dst_addr  = dst;
    bus.cmd_num_lines = n;
    bus.cmd_alloc     = alloc;
    bus.cmd_valid     = 1'b1;
    step();
    bus.cmd_valid     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    i = 0;
    while (!bus.done && i < budget) begin
      step();
      i++;
    end
    chk({tag, "_done_seen"}, 64'(bus.done), 64'(1));
  endtask

  task automatic pulse_ld();
    man_ld = 1'b1;
    step();
    man_ld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int i;
    bus.cmd_valid     = 1'b0;
    bus.cmd_src_addr  = '0;
    bus.cmd_dst_addr  = '0;
    bus.cmd_num_lines = '0;
    bus.cmd_alloc     = 1'b0;
    bus.ar_ready      = 1'b1;
    bus.aw_ready      = 1'b1;

    // Reset state
    step(3);
    chk("rst_status", 64'({bus.cmd_ready, bus.busy, bus.done, bus.ar_valid, bus.aw_valid}), 64'(5'b10000));
    chk("rst_lines_done", 64'(bus.lines_done), 64'(0));
    chk("rst_addrs", 64'({bus.ar_addr, bus.aw_addr}), 64'(0));
    chk("rst_id_srcdst", 64'({bus.ar_id, bus.aw_id, bus.ar_src_dst, bus.aw_src_dst}), 64'(0));
    rst_ni = 1'b1;
    step(2);

    // Alloc, N=4, auto completion
    ar_q.delete(); aw_q.delete(); d0 = done_n; auto_en = 1'b1;
    send_cmd(32'h8000_0000, 32'hF000_0000, 8'd4, 1'b1);
    chk("t1_busy", 64'(bus.busy), 64'(1));
    chk("t1_ar_valid", 64'(bus.ar_valid), 64'(1));
    chk("t1_aw_valid_early", 64'(bus.aw_valid), 64'(0));
    chk("t1_src_dst", 64'({bus.ar_src_dst, bus.aw_src_dst}), 64'(2'b11));
    chk("t1_cmd_ready_busy", 64'(bus.cmd_ready), 64'(0));
    wait_done("t1", 60);
    step(3);
    chk("t1_done_once", 64'(done_n - d0), 64'(1));
    chk("t1_lines_done", 64'(bus.lines_done), 64'(4));
    chk("t1_ar_count", 64'(ar_q.size()), 64'(4));
    chk("t1_aw_count", 64'(aw_q.size()), 64'(4));
    for (int k = 0; k < 4; k++) begin
      chk("t1_ar_addr", 64'(ar_q[k]), 64'(T1_AR[k]));
      chk("t1_aw_addr", 64'(aw_q[k]), 64'(T1_AW[k]));
    end

    // Outstanding limit, completions withheld
    ar_q.delete(); aw_q.delete(); auto_en = 1'b0;
    send_cmd(32'h0000_1000, 32'h0000_2000, 8'd6, 1'b1);
    step(12);
    chk("t2_aw_held", 64'(aw_q.size()), 64'(2));
    chk("t2_aw_valid_low", 64'(bus.aw_valid), 64'(0));
    chk("t2_ar_count", 64'(ar_q.size()), 64'(6));
    chk("t2_aw_addr1", 64'(aw_q[1]), 64'(32'h0000_2040));
    for (int k = 0; k < 4; k++) begin
      pulse_ld();
      step(3);
      chk("t2_aw_release", 64'(aw_q.size()), 64'(3 + k));
    end
    chk("t2_lines_mid", 64'(bus.lines_done), 64'(4));
    pulse_ld();
    step(2);
    chk("t2_not_done", 64'(bus.busy), 64'(1));
    pulse_ld();
    chk("t2_done_latency", 64'({bus.done, bus.cmd_ready, bus.busy}), 64'(3'b110));
    chk("t2_lines_done", 64'(bus.lines_done), 64'(6));
    step(2);

    // AR backpressure, N=3
    ar_q.delete(); aw_q.delete(); auto_en = 1'b1; bus.ar_ready = 1'b0;
    send_cmd(32'h4000_0100, 32'h5000_0000, 8'd3, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk("t3_stall", 64'({bus.ar_valid, bus.ar_addr, bus.aw_valid}), {30'd0, 1'b1, 32'h4000_0100, 1'b0});
      step();
    end
    bus.ar_ready = 1'b1;
    chk("t3_aw_before_ar", 64'(bus.aw_valid), 64'(0));
    step();
    chk("t3_aw_after_ar", 64'(bus.aw_valid), 64'(1));
    wait_done("t3", 40);
    step(2);
    chk("t3_ar_count", 64'(ar_q.size()), 64'(3));
    for (int k = 0; k < 3; k++) begin
      chk("t3_ar_addr", 64'(ar_q[k]), 64'(T3_AR[k]));
      chk("t3_aw_addr", 64'(aw_q[k]), 64'(T3_AW[k]));
    end

    // Zero-length writeback
    ar_q.delete(); aw_q.delete(); d0 = done_n;
    send_cmd(32'h1234_5600, 32'h6543_2100, 8'd0, 1'b0);
    chk("t4_busy", 64'({bus.busy, bus.done}), 64'(2'b10));
    chk("t4_no_valid", 64'({bus.ar_valid, bus.aw_valid}), 64'(0));
    chk("t4_src_dst", 64'({bus.ar_src_dst, bus.aw_src_dst}), 64'(0));
    step();
    chk("t4_done", 64'({bus.done, bus.busy, bus.cmd_ready}), 64'(3'b101));
    step(2);
    chk("t4_no_xfers", 64'(ar_q.size() + aw_q.size()), 64'(0));
    chk("t4_done_once", 64'(done_n - d0), 64'(1));

    // Source address wrap
    ar_q.delete(); aw_q.delete();
    send_cmd(32'hFFFF_FFC0, 32'h0000_0100, 8'd2, 1'b1);
    wait_done("t5", 40);
    step(2);
    chk("t5_ar_count", 64'(ar_q.size()), 64'(2));
    chk("t5_ar_addr0", 64'(ar_q[0]), 64'(32'hFFFF_FFC0));
    chk("t5_ar_addr1", 64'(ar_q[1]), 64'(32'h0000_0000));

    // Reset mid-ISSUE, then immediate new command plus stray completions
    ar_q.delete(); aw_q.delete();
    send_cmd(32'h0000_3000, 32'h0000_6000, 8'd5, 1'b1);
    i = 0;
    while (ar_q.size() < 2 && i < 20) begin
      step();
      i++;
    end
    chk("t6_two_lines", 64'(ar_q.size()), 64'(2));
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_status", 64'({bus.cmd_ready, bus.busy, bus.done, bus.ar_valid, bus.aw_valid}), 64'(5'b10000));
    chk("t6_rst_lines", 64'(bus.lines_done), 64'(0));
    chk("t6_rst_addrs", 64'({bus.ar_addr, bus.aw_addr, bus.ar_src_dst, bus.aw_src_dst}), 64'(0));
    step(2);
    rst_ni            = 1'b1;
    bus.cmd_src_addr  = 32'h0000_7000;
    bus.cmd_dst_addr  = 32'h0000_7100;
    bus.cmd_num_lines = 8'd1;
    bus.cmd_alloc     = 1'b0;
    bus.cmd_valid     = 1'b1;
    man_ld            = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    chk("t6_accept", 64'({bus.busy, bus.ar_valid}), 64'(2'b11));
    chk("t6_stray_idle", 64'(bus.lines_done), 64'(0));
    step();
    man_ld = 1'b0;
    chk("t6_stray_issue", 64'(bus.lines_done), 64'(0));
    wait_done("t6", 30);
    chk("t6_lines_done", 64'(bus.lines_done), 64'(1));
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axi_llc_arcane_xfer_seq.md
# axi_llc_arcane_xfer_seq

Sequencer for ARCANE line-copy operations. It takes one software command (source address, destination address, line count, direction) and emits a stream of single-line AR and AW requests. Each request feeds the AR-side or AW-side AXI-to-descriptor converter of the LLC, which marks it as alloc-src or writeback. The block throttles the stream by an outstanding-write limit, counts completions, and signals when the whole operation is done.

## Interface
- AddrWidth, 32: address width of command and AX outputs.
- IdWidth, 4: AXI ID width.
- TxnId, 0: constant ID driven on every AR/AW.
- LineBytes, 64: bytes per line; power of two; address stride.
- NumLinesWidth, 8: width of the line-count field.
- MaxOutstanding, 4: maximum AW lines issued but not yet completed; at least 1.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_src_addr_i  in  AddrWidth  first source line address.
- cmd_dst_addr_i  in  AddrWidth  first destination line address.
- cmd_num_lines_i  in  NumLinesWidth  line count; 0 is legal.
- cmd_alloc_i  in  1  1 = alloc (mem→LLC), 0 = writeback (LLC→mem).
- ar_valid_o / ar_ready_i  out/in  1  read-request handshake.
- ar_addr_o  out  AddrWidth  read address.
- ar_id_o  out  IdWidth  = TxnId.
- ar_src_dst_o  out  1  src/dst type flag for the AR converter.
- aw_valid_o / aw_ready_i  out/in  1  write-request handshake.
- aw_addr_o  out  AddrWidth  write address.
- aw_id_o  out  IdWidth  = TxnId.
- aw_src_dst_o  out  1  src/dst type flag for the AW converter.
- line_done_i  in  1  single-cycle pulse, one per completed line write (B response).
- busy_o  out  1  operation in progress.
- done_o  out  1  single-cycle pulse at operation end.
- lines_done_o  out  NumLinesWidth  completed lines of the current or last operation.

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - cmd_ready_o=1.
  - On accept, latch src, dst, count N and alloc; clear ar_cnt, aw_cnt, out_cnt and lines_done_o.
  - Go to ISSUE if N≠0, else DRAIN.
- ISSUE, AR side:
  - ar_valid_o=1 while ar_cnt<N.
  - ar_addr_o = src + ar_cnt·LineBytes, modulo 2^AddrWidth.
  - ar_cnt increments on an AR handshake.
- ISSUE, AW side:
  - aw_valid_o=1 while aw_cnt<ar_cnt and out_cnt<MaxOutstanding.
  - aw_addr_o = dst + aw_cnt·LineBytes, modulo 2^AddrWidth.
  - AW never runs ahead of AR; a same-cycle AR handshake does not enable AW in that cycle.
- Outstanding counter:
  - out_cnt +1 on an AW handshake, −1 on line_done_i.
  - Both in the same cycle: out_cnt unchanged.
  - lines_done_o +1 on each line_done_i.
- ar_src_dst_o = aw_src_dst_o = latched alloc flag, held for the whole operation.
- ISSUE→DRAIN when aw_cnt reaches N.
- DRAIN→IDLE when lines_done_o==N. done_o is pulsed in the cycle the FSM re-enters IDLE.
- busy_o=1 in ISSUE and DRAIN.
- Unexpected line_done_i:
  - In IDLE: ignored.
  - When out_cnt=0: ignored, no underflow.
  - lines_done_o saturates at N.
- valid/addr on AR and AW are stable until handshake (AXI rule); valid never drops without ready.
- No new command is accepted while busy.

## Timing
- Reset values:
  - state IDLE, all counters 0.
  - cmd_ready_o=1.
  - ar_valid_o=0, aw_valid_o=0, busy_o=0, done_o=0, lines_done_o=0.
  - addr, id and src_dst outputs are 0.
- All AX outputs and status outputs are registered. No combinational path from ar_ready_i, aw_ready_i or line_done_i to any output.
- Cycle-level latency:
  - Command accepted at cycle t: busy_o=1 and ar_valid_o=1 at t+1.
  - First AR handshake at t+1: aw_valid_o=1 at t+2, at the earliest.
  - Final line_done_i at cycle u: done_o=1 and cmd_ready_o=1 at u+1.
- Zero-length command at t: done_o at t+2; busy_o high for one cycle only (t+1).
- Peak throughput with no backpressure: one AR and one AW per cycle.
- Reset asserted mid-operation aborts immediately to reset values. In-flight completions arriving after reset are ignored.

## Test plan
- Alloc, N=4, src=0x8000_0000, dst=0xF000_0000, LineBytes=64, ready held 1, line_done_i 2 cycles after each AW:
  - ar_addr 0x8000_0000/40/80/C0; aw_addr 0xF000_0000/40/80/C0; src_dst=1.
  - done_o exactly once; lines_done_o=4.
- Outstanding limit, MaxOutstanding=2, N=6, line_done_i withheld:
  - exactly 2 AW handshakes, then aw_valid_o=0 and AR continues to 6.
  - each line_done_i pulse releases one further AW.
- Backpressure, ar_ready_i low for 5 cycles then high, N=3:
  - ar_valid/ar_addr stable during the stall; aw_valid_o stays 0 until the first AR handshake.
- Zero-length writeback (N=0, alloc=0):
  - no AR/AW valid; done_o one cycle after busy_o; src_dst outputs 0.
- Address wrap, src=0xFFFF_FFC0, N=2:
  - ar_addr 0xFFFF_FFC0 then 0x0000_0000.
- Reset mid-ISSUE after 2 of 5 lines:
  - all outputs return to reset values; a new command is accepted in the first cycle after reset release.
  - the stray line_done_i that follows leaves lines_done_o at 0.
